// File: rtl/movavg_frame_stats_pkg.sv
// Shared constants and types for the movavg frame statistics block.
// Word length and tap count mirror the upstream 4-tap moving-sum stage.
package movavg_frame_stats_pkg;

  // Data word of the movavg stage: 64 bits, msb index 63.
  localparam int MOVAVG_WL        = 64;
  localparam int MOVAVG_WL_MSB    = MOVAVG_WL - 1;

  // The moving sum covers 4 taps, so the average is the sum shifted right by 2.
  localparam int MOVAVG_TAPS      = 4;
  localparam int MOVAVG_TAP_SHIFT = 2;

  // Output port state. The state bit is out_valid itself.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Unsigned minimum / maximum of two words.
  function automatic logic [MOVAVG_WL-1:0] umin(input logic [MOVAVG_WL-1:0] a,
                                                input logic [MOVAVG_WL-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [MOVAVG_WL-1:0] umax(input logic [MOVAVG_WL-1:0] a,
                                                input logic [MOVAVG_WL-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/movavg_frame_stats_frame_accum.sv
// Per-frame accumulator: counts valid samples, tracks running min/max and
// the sum of averages. On the last sample of a frame it raises frame_done for
// one cycle together with the final statistics, which already include that
// sample, so the consumer can register them on the same edge.
module frame_accum
  import movavg_frame_stats_pkg::*;
#(
  parameter int WL         = MOVAVG_WL,
  parameter int LOG2_FRAME = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [WL-1:0] din,
  output logic          frame_done,
  output logic [WL-1:0] fin_min,
  output logic [WL-1:0] fin_max,
  output logic [WL-1:0] fin_mean
);

  // A zero-width counter is not legal, so LOG2_FRAME=0 keeps a 1-bit counter
  // whose last value is 0: every sample is both first and last of its frame.
  localparam int              CW       = (LOG2_FRAME > 0) ? LOG2_FRAME : 1;
  localparam int              AW       = WL + LOG2_FRAME;
  localparam logic [CW-1:0]   CNT_LAST = CW'((1 << LOG2_FRAME) - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [WL-1:0] run_min_q, run_max_q;
  logic [AW-1:0] acc_q, acc_d;
  logic [WL-1:0] avg;
  logic [WL-1:0] min_d, max_d;
  logic          first;

  // Scale the moving sum to an average and fold it into the running statistics.
  always_comb begin
    avg        = din >> MOVAVG_TAP_SHIFT;
    first      = (cnt_q == '0);
    min_d      = first ? avg : ((avg < run_min_q) ? avg : run_min_q);
    max_d      = first ? avg : ((avg > run_max_q) ? avg : run_max_q);
    acc_d      = first ? AW'(avg) : (acc_q + AW'(avg));
    cnt_d      = (cnt_q == CNT_LAST) ? '0 : (cnt_q + CW'(1));
    frame_done = in_valid && (cnt_q == CNT_LAST);
    fin_min    = min_d;
    fin_max    = max_d;
    fin_mean   = acc_d[AW-1:LOG2_FRAME];
  end

  // Running state advances only on valid samples; idle cycles hold everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      run_min_q <= '0;
      run_max_q <= '0;
      acc_q     <= '0;
    end else if (in_valid) begin
      cnt_q     <= cnt_d;
      run_min_q <= min_d;
      run_max_q <= max_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: rtl/movavg_frame_stats.sv
// Frame statistics over averaged movavg sums. One min/max/mean result per
// frame is offered on a valid/ready port; a frame that completes while a
// previous result is still waiting and not being taken is dropped and the
// sticky overrun flag is set.
//
// Handshake: out_valid && out_ready on a rising edge is a transfer. While
// out_valid is high and out_ready low the result outputs hold steady.
// out_valid never depends combinationally on out_ready.
module movavg_frame_stats
  import movavg_frame_stats_pkg::*;
#(
  parameter int WL         = MOVAVG_WL,
  parameter int LOG2_FRAME = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [WL-1:0] din,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [WL-1:0] min_avg,
  output logic [WL-1:0] max_avg,
  output logic [WL-1:0] mean_avg,
  output logic          overrun,
  output out_state_e    fsm_state
);

  logic          frame_done;
  logic [WL-1:0] fin_min, fin_max, fin_mean;

  out_state_e    state_q, state_d;
  logic          load_res;
  logic          set_ovr;
  logic          overrun_q;
  logic [WL-1:0] min_q, max_q, mean_q;

  frame_accum #(
    .WL         (WL),
    .LOG2_FRAME (LOG2_FRAME)
  ) u_frame_accum (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .din        (din),
    .frame_done (frame_done),
    .fin_min    (fin_min),
    .fin_max    (fin_max),
    .fin_mean   (fin_mean)
  );

  // Output FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Next state, result load and overrun decisions.
  always_comb begin
    state_d  = state_q;
    load_res = 1'b0;
    set_ovr  = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (frame_done) begin
          load_res = 1'b1;
          state_d  = ST_FULL;
        end
      end
      ST_FULL: begin
        if (frame_done) begin
          // Held result leaves this edge if accepted, so the new one can replace it.
          if (out_ready) load_res = 1'b1;
          else           set_ovr  = 1'b1;
          state_d = ST_FULL;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Result registers, loaded only when a finished frame is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_q  <= '0;
      max_q  <= '0;
      mean_q <= '0;
    end else if (load_res) begin
      min_q  <= fin_min;
      max_q  <= fin_max;
      mean_q <= fin_mean;
    end
  end

  // Sticky overrun, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       overrun_q <= 1'b0;
    else if (set_ovr) overrun_q <= 1'b1;
  end

  assign out_valid = (state_q == ST_FULL);
  assign min_avg   = min_q;
  assign max_avg   = max_q;
  assign mean_avg  = mean_q;
  assign overrun   = overrun_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_movavg_frame_stats.sv
// Bench for movavg_frame_stats. Two instances share the input stream:
// dut with 4-sample frames and dut0 with 1-sample frames (ready tied high).
// A reference model computes frame results from collected sample lists.
module tb_movavg_frame_stats;
  import movavg_frame_stats_pkg::*;

  localparam int WL         = 64;
  localparam int LOG2_FRAME = 2;
  localparam int FRAME_LEN  = 1 << LOG2_FRAME;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [WL-1:0] din;
  logic          out_ready;
  logic          out_valid;
  logic [WL-1:0] min_avg, max_avg, mean_avg;
  logic          overrun;
  out_state_e    fsm_state;

  logic          out_ready0;
  logic          out_valid0;
  logic [WL-1:0] min_avg0, max_avg0, mean_avg0;
  logic          overrun0;
  out_state_e    fsm_state0;

  always #5 clk = ~clk;

  movavg_frame_stats #(.WL(WL), .LOG2_FRAME(LOG2_FRAME)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .din(din),
    .out_ready(out_ready), .out_valid(out_valid), .min_avg(min_avg),
    .max_avg(max_avg), .mean_avg(mean_avg), .overrun(overrun),
    .fsm_state(fsm_state)
  );

  movavg_frame_stats #(.WL(WL), .LOG2_FRAME(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .din(din),
    .out_ready(out_ready0), .out_valid(out_valid0), .min_avg(min_avg0),
    .max_avg(max_avg0), .mean_avg(mean_avg0), .overrun(overrun0),
    .fsm_state(fsm_state0)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [WL-1:0] act, input logic [WL-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected entries are {min, max, mean}.
  logic [3*WL-1:0] exp_q[$];
  logic [3*WL-1:0] exp0_q[$];
  logic [WL-1:0]   frame_q[$];
  logic            m_full;
  logic            m_ovr;

  function automatic logic [3*WL-1:0] frame_result(input logic [WL-1:0] s[$]);
    logic [WL-1:0]    mn, mx;
    logic [WL+15:0]   sum;
    mn  = s[0];
    mx  = s[0];
    sum = '0;
    foreach (s[i]) begin
      if (s[i] < mn) mn = s[i];
      if (s[i] > mx) mx = s[i];
      sum = sum + {16'd0, s[i]};
    end
    sum = sum / s.size();
    return {mn, mx, sum[WL-1:0]};
  endfunction

  // Observe the inputs at each edge and predict what the DUTs will present.
  always @(posedge clk or negedge reset) begin
    logic            fend;
    logic [3*WL-1:0] res;
    if (!reset) begin
      exp_q.delete();
      exp0_q.delete();
      frame_q.delete();
      m_full = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      fend = 1'b0;
      res  = '0;
      if (in_valid) begin
        frame_q.push_back(din / 4);
        exp0_q.push_back({din / 4, din / 4, din / 4});
        if (frame_q.size() == FRAME_LEN) begin
          res  = frame_result(frame_q);
          fend = 1'b1;
          frame_q.delete();
        end
      end
      if (fend) begin
        if (m_full && !out_ready) m_ovr = 1'b1;
        else begin
          exp_q.push_back(res);
          m_full = 1'b1;
        end
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // ---------------- monitors ----------------
  logic [3*WL-1:0] front;

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_out_valid", WL'(out_valid), '0);
      check("rst_overrun",   WL'(overrun),   '0);
      check("rst_min",       min_avg,        '0);
      check("rst_max",       max_avg,        '0);
      check("rst_mean",      mean_avg,       '0);
    end else begin
      check("out_valid", WL'(out_valid), WL'(m_full));
      check("fsm_state", WL'(fsm_state), WL'(m_full));
      check("overrun",   WL'(overrun),   WL'(m_ovr));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("result_expected", WL'(1), WL'(0));
        end else begin
          front = exp_q[0];
          check("min_avg",  min_avg,  front[3*WL-1:2*WL]);
          check("max_avg",  max_avg,  front[2*WL-1:WL]);
          check("mean_avg", mean_avg, front[WL-1:0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  logic [3*WL-1:0] front0;

  always @(negedge clk) begin
    if (reset) begin
      check("f0_out_valid", WL'(out_valid0), WL'(exp0_q.size() != 0));
      check("f0_overrun",   WL'(overrun0),   '0);
      if (out_valid0 && exp0_q.size() != 0) begin
        front0 = exp0_q.pop_front();
        check("f0_min",  min_avg0,  front0[3*WL-1:2*WL]);
        check("f0_max",  max_avg0,  front0[2*WL-1:WL]);
        check("f0_mean", mean_avg0, front0[WL-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [WL-1:0] d);
    @(posedge clk); #1;
    in_valid = 1'b1;
    din      = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset    = 1'b1;
  endtask

  task automatic send_ramp();
    send(64'd4); send(64'd8); send(64'd12); send(64'd16);
  endtask

  task automatic check_held(input string tag, input logic [WL-1:0] mn,
                            input logic [WL-1:0] mx, input logic [WL-1:0] me);
    check({tag, "_valid"}, WL'(out_valid), WL'(1));
    check({tag, "_min"},   min_avg, mn);
    check({tag, "_max"},   max_avg, mx);
    check({tag, "_mean"},  mean_avg, me);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WL-1:0] ones;
    ones       = '1;
    reset      = 1'b0;
    in_valid   = 1'b0;
    din        = '0;
    out_ready  = 1'b0;
    out_ready0 = 1'b1;

    // 1: reset for two cycles
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("t1_out_valid", WL'(out_valid), '0);
    check("t1_overrun",   WL'(overrun),   '0);
    check("t1_min",       min_avg,        '0);
    check("t1_max",       max_avg,        '0);
    check("t1_mean",      mean_avg,       '0);

    // 2: back-to-back frame, ready high
    out_ready = 1'b1;
    send_ramp();
    idle(1);
    check_held("t2", 64'd1, 64'd4, 64'd2);
    idle(1);
    check("t2_valid_drop", WL'(out_valid), '0);

    // 3: same frame with idle gaps
    send(64'd4);  idle(3);
    send(64'd8);  idle(3);
    send(64'd12); idle(3);
    send(64'd16);
    idle(1);
    check_held("t3", 64'd1, 64'd4, 64'd2);
    idle(1);
    check("t3_valid_drop", WL'(out_valid), '0);

    // 4: two frames while blocked -> second dropped, overrun
    out_ready = 1'b0;
    send_ramp();
    send(64'd40); send(64'd40); send(64'd40); send(64'd40);
    idle(1);
    check_held("t4", 64'd1, 64'd4, 64'd2);
    check("t4_overrun", WL'(overrun), WL'(1));
    idle(2);
    check_held("t4_hold", 64'd1, 64'd4, 64'd2);
    out_ready = 1'b1;
    idle(1);
    check("t4_after_xfer", WL'(out_valid), '0);
    check("t4_overrun_sticky", WL'(overrun), WL'(1));

    // 5: frame end coincides with transfer of the held result
    do_reset();
    out_ready = 1'b0;
    send_ramp();
    idle(3);
    send(64'd40); send(64'd40); send(64'd40);
    send(64'd40);
    out_ready = 1'b1;
    idle(1);
    check_held("t5", 64'd10, 64'd10, 64'd10);
    check("t5_overrun", WL'(overrun), '0);
    idle(1);
    check("t5_valid_drop", WL'(out_valid), '0);

    // 6: mid-frame reset then full-scale samples
    send(64'd100); send(64'd200);
    do_reset();
    send(ones); send(ones); send(ones); send(ones);
    idle(1);
    check_held("t6", 64'h3FFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF,
               64'h3FFF_FFFF_FFFF_FFFF);
    idle(2);

    // Randomized traffic with random backpressure
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 5))
        0:       din = ones;
        1:       din = WL'($urandom_range(0, 15));
        default: din = {$urandom(), $urandom()};
      endcase
      if (i == 200) begin
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
      end
    end

    // Drain
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(4);
    check("drain_exp_q",  WL'(exp_q.size()),  '0);
    check("drain_exp0_q", WL'(exp0_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
